// File: rtl/instr_dcd.sv
// Command/data byte decoder sitting behind an SPI byte bridge.
// The first byte of a frame is a command (bit7 write/read, bit6 auto-increment,
// bits[5:0] start address); each following byte is a data byte that turns into
// a one-cycle register write or read strobe. Reads prefetch one register ahead
// so the value is ready in data_out before the bridge has to shift it out.
module instr_dcd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       byte_sync,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       read,
  output logic       write,
  output logic [5:0] addr,
  output logic [7:0] data_write,
  input  logic [7:0] data_read
);

  typedef enum logic {
    CMD  = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic       writeMode_q, writeMode_d;
  logic       autoInc_q, autoInc_d;
  logic [5:0] curAddr_q, curAddr_d;
  logic [5:0] addr_q, addr_d;
  logic       read_q, read_d;
  logic       write_q, write_d;
  logic [7:0] dataWrite_q, dataWrite_d;
  logic [7:0] dataOut_q, dataOut_d;
  logic [5:0] stepAddr;

  // Address used by the next data byte's access; wraps 63 -> 0 naturally.
  assign stepAddr = autoInc_q ? (curAddr_q + 6'd1) : curAddr_q;

  // Decode received bytes into strobes and track frame state.
  // curAddr_q is the internal pointer; addr_q only moves when a strobe fires,
  // so the visible address holds between accesses.
  always_comb begin
    state_d     = state_q;
    writeMode_d = writeMode_q;
    autoInc_d   = autoInc_q;
    curAddr_d   = curAddr_q;
    addr_d      = addr_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    dataWrite_d = dataWrite_q;
    dataOut_d   = read_q ? data_read : dataOut_q;

    if (cs_n) begin
      state_d = CMD;
    end else if (byte_sync) begin
      case (state_q)
        CMD: begin
          writeMode_d = data_in[7];
          autoInc_d   = data_in[6];
          curAddr_d   = data_in[5:0];
          state_d     = DATA;
          if (!data_in[7]) begin
            read_d = 1'b1;
            addr_d = data_in[5:0];
          end
        end
        DATA: begin
          if (writeMode_q) begin
            write_d     = 1'b1;
            addr_d      = curAddr_q;
            dataWrite_d = data_in;
            curAddr_d   = stepAddr;
          end else begin
            read_d    = 1'b1;
            addr_d    = stepAddr;
            curAddr_d = stepAddr;
          end
        end
        default: state_d = CMD;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CMD;
      writeMode_q <= 1'b0;
      autoInc_q   <= 1'b0;
      curAddr_q   <= 6'd0;
      addr_q      <= 6'd0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      dataWrite_q <= 8'h00;
      dataOut_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      writeMode_q <= writeMode_d;
      autoInc_q   <= autoInc_d;
      curAddr_q   <= curAddr_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      write_q     <= write_d;
      dataWrite_q <= dataWrite_d;
      dataOut_q   <= dataOut_d;
    end
  end

  assign data_out   = dataOut_q;
  assign read       = read_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign data_write = dataWrite_q;

endmodule

// File: tb/tb_instr_dcd.sv
// Directed bench for instr_dcd: single and burst reads/writes, wrap-around,
// back-to-back bytes, frame abort and mid-frame reset.
module tb_instr_dcd;

  logic       clk;
  logic       rst_n;
  logic       cs_n;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;

  logic [7:0] mem [64];
  int checks = 0;
  int errors = 0;
  int readCnt = 0;
  int writeCnt = 0;

  instr_dcd dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data_write (data_write),
    .data_read  (data_read)
  );

  // Register file model answering read strobes combinationally.
  assign data_read = mem[addr];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobes and flag read/write overlap on every sampled cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (read)  readCnt++;
      if (write) writeCnt++;
      checks++;
      if (read && write) begin
        errors++;
        $display("[TB] FAIL strobe_overlap: read=%0b write=%0b, required not both 1", read, write);
      end
    end
  end

  // Present one byte for one cycle; returns at the sample point of byte_sync+1.
  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    byte_sync = 1'b1;
    data_in   = b;
    @(negedge clk);
    byte_sync = 1'b0;
    data_in   = 8'h00;
  endtask

  // Deselect for a couple of cycles so the decoder returns to CMD.
  task automatic endFrame();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({data_out, read, write, addr, data_write} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, required 000000",
               {data_out, read, write, addr, data_write});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_single();
    int w0, r0;
    w0 = writeCnt; r0 = readCnt;
    @(negedge clk); cs_n = 1'b0;
    sendByte(8'h85);
    checks++;
    if (write !== 1'b0 || read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_cmd_no_strobe: read=%0b write=%0b, required 0 0", read, write);
    end
    sendByte(8'h3C);
    checks++;
    if (write !== 1'b1 || addr !== 6'd5 || data_write !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL wr_single: write=%0b addr=%0d data=%h, required 1 5 3c", write, addr, data_write);
    end
    endFrame();
    checks++;
    if (writeCnt - w0 !== 1 || readCnt - r0 !== 0) begin
      errors++;
      $display("[TB] FAIL wr_single_count: writes=%0d reads=%0d, required 1 0", writeCnt - w0, readCnt - r0);
    end
  endtask

  task automatic test_read_single();
    @(negedge clk); cs_n = 1'b0;
    sendByte(8'h0A);
    checks++;
    if (read !== 1'b1 || addr !== 6'd10) begin
      errors++;
      $display("[TB] FAIL rd_strobe: read=%0b addr=%0d, required 1 10", read, addr);
    end
    @(negedge clk);
    checks++;
    if (data_out !== 8'h77 || read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_data: data_out=%h read=%0b, required 77 0", data_out, read);
    end
    endFrame();
    repeat (2) @(negedge clk);
    checks++;
    if (data_out !== 8'h77 || addr !== 6'd10) begin
      errors++;
      $display("[TB] FAIL rd_hold: data_out=%h addr=%0d, required 77 10", data_out, addr);
    end
  endtask

  task automatic test_write_burst();
    logic [7:0] dat [3];
    logic [5:0] exp [3];
    dat = '{8'h11, 8'h22, 8'h33};
    exp = '{6'd62, 6'd63, 6'd0};
    @(negedge clk); cs_n = 1'b0;
    sendByte(8'hFE);
    for (int i = 0; i < 3; i++) begin
      sendByte(dat[i]);
      checks++;
      if (write !== 1'b1 || addr !== exp[i] || data_write !== dat[i]) begin
        errors++;
        $display("[TB] FAIL wr_burst[%0d]: write=%0b addr=%0d data=%h, required 1 %0d %h",
                 i, write, addr, data_write, exp[i], dat[i]);
      end
    end
    endFrame();
  endtask

  task automatic test_read_burst();
    logic [5:0] exp [3];
    exp = '{6'd63, 6'd0, 6'd1};
    @(negedge clk); cs_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sendByte(i == 0 ? 8'h7F : 8'hEE);
      checks++;
      if (read !== 1'b1 || addr !== exp[i]) begin
        errors++;
        $display("[TB] FAIL rd_burst_addr[%0d]: read=%0b addr=%0d, required 1 %0d", i, read, addr, exp[i]);
      end
      @(negedge clk);
      checks++;
      if (data_out !== mem[exp[i]]) begin
        errors++;
        $display("[TB] FAIL rd_burst_data[%0d]: data_out=%h, required %h", i, data_out, mem[exp[i]]);
      end
    end
    endFrame();
  endtask

  task automatic test_no_autoinc();
    @(negedge clk); cs_n = 1'b0;
    sendByte(8'h83);
    sendByte(8'h01);
    checks++;
    if (write !== 1'b1 || addr !== 6'd3 || data_write !== 8'h01) begin
      errors++;
      $display("[TB] FAIL noinc_wr0: write=%0b addr=%0d data=%h, required 1 3 01", write, addr, data_write);
    end
    sendByte(8'h02);
    checks++;
    if (write !== 1'b1 || addr !== 6'd3 || data_write !== 8'h02) begin
      errors++;
      $display("[TB] FAIL noinc_wr1: write=%0b addr=%0d data=%h, required 1 3 02", write, addr, data_write);
    end
    endFrame();
  endtask

  task automatic test_back_to_back();
    logic [7:0] dat [3];
    dat = '{8'hA1, 8'hA2, 8'hA3};
    @(negedge clk); cs_n = 1'b0;
    @(negedge clk); byte_sync = 1'b1; data_in = 8'hC0;
    @(negedge clk); data_in = dat[0];
    checks++;
    if (write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_cmd: write=%0b, required 0", write);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) data_in = dat[i + 1];
      else begin byte_sync = 1'b0; data_in = 8'h00; end
      checks++;
      if (write !== 1'b1 || addr !== 6'(i) || data_write !== dat[i]) begin
        errors++;
        $display("[TB] FAIL b2b[%0d]: write=%0b addr=%0d data=%h, required 1 %0d %h",
                 i, write, addr, data_write, i, dat[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: write=%0b, required 0", write);
    end
    endFrame();
  endtask

  task automatic test_abort();
    int w0;
    w0 = writeCnt;
    @(negedge clk); cs_n = 1'b0;
    sendByte(8'h81);
    cs_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    sendByte(8'h02);
    checks++;
    if (read !== 1'b1 || write !== 1'b0 || addr !== 6'd2) begin
      errors++;
      $display("[TB] FAIL abort_recmd: read=%0b write=%0b addr=%0d, required 1 0 2", read, write, addr);
    end
    @(negedge clk);
    checks++;
    if (data_out !== mem[2] || writeCnt !== w0) begin
      errors++;
      $display("[TB] FAIL abort_data: data_out=%h writes=%0d, required %h %0d",
               data_out, writeCnt - w0, mem[2], 0);
    end
    endFrame();
  endtask

  task automatic test_ignore_deselected();
    sendByte(8'h0B);
    checks++;
    if (read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_cs_high: read=%0b, required 0", read);
    end
    @(negedge clk); cs_n = 1'b0;
    sendByte(8'h84);
    checks++;
    if (read !== 1'b0 || write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_then_cmd: read=%0b write=%0b, required 0 0", read, write);
    end
    sendByte(8'h99);
    checks++;
    if (write !== 1'b1 || addr !== 6'd4 || data_write !== 8'h99) begin
      errors++;
      $display("[TB] FAIL ignore_then_wr: write=%0b addr=%0d data=%h, required 1 4 99", write, addr, data_write);
    end
    endFrame();
  endtask

  task automatic test_reset_midburst();
    @(negedge clk); cs_n = 1'b0;
    sendByte(8'hC8);
    sendByte(8'h10);
    @(negedge clk);
    byte_sync = 1'b1;
    data_in   = 8'h20;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, read, write, addr, data_write} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_async: got %h, required 000000", {data_out, read, write, addr, data_write});
    end
    @(negedge clk);
    checks++;
    if (write !== 1'b0 || addr !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_abort: write=%0b addr=%0d, required 0 0", write, addr);
    end
    byte_sync = 1'b0;
    data_in   = 8'h00;
    rst_n     = 1'b1;
    sendByte(8'h0C);
    checks++;
    if (read !== 1'b1 || write !== 1'b0 || addr !== 6'd12) begin
      errors++;
      $display("[TB] FAIL reset_first_cmd: read=%0b write=%0b addr=%0d, required 1 0 12", read, write, addr);
    end
    endFrame();
  endtask

  // Run every scenario in order, then report.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h40 + 8'(i);
    mem[10]   = 8'h77;
    rst_n     = 1'b0;
    cs_n      = 1'b1;
    byte_sync = 1'b0;
    data_in   = 8'h00;

    test_reset();
    test_write_single();
    test_read_single();
    test_write_burst();
    test_read_burst();
    test_no_autoinc();
    test_back_to_back();
    test_abort();
    test_ignore_deselected();
    test_reset_midburst();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_dcd.md
INSTR_DCD -- requirements
Module: instr_dcd

Interface
REQ-001 SHALL have port clk  input  1  peripheral clock; all logic on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port cs_n  input  1  SPI chip select (synchronous to clk); high = frame inactive.
REQ-004 SHALL have port byte_sync  input  1  one-cycle pulse; a complete byte from the SPI bridge is on data_in.
REQ-005 SHALL have port data_in  input  8  received byte; valid only in the byte_sync cycle.
REQ-006 SHALL have port data_out  output  8  byte returned to the SPI bridge for shifting out on MISO.
REQ-007 SHALL have port read  output  1  one-cycle register read strobe.
REQ-008 SHALL have port write  output  1  one-cycle register write strobe.
REQ-009 SHALL have port addr  output  6  register address for read/write.
REQ-010 SHALL have port data_write  output  8  write data; valid while write=1.
REQ-011 SHALL have port data_read  input  8  register read data; combinational response, valid in the same cycle as read=1.

Function
REQ-012 SHALL implement FSM states CMD (expect command byte) and DATA (expect data byte).
REQ-013 SHALL decode the command byte as: bit7 = 1 write / 0 read; bit6 = auto-increment enable; bits[5:0] = start address.
REQ-014 In CMD, on byte_sync with cs_n=0: SHALL latch mode, auto-increment and address, then go to DATA.
REQ-015 On a read command: SHALL assert read=1 with addr=start address in the cycle after byte_sync (latency 1).
REQ-016 In any cycle with read=1: SHALL capture data_read into data_out at that cycle's closing edge, so data_out is valid 2 cycles after byte_sync.
REQ-017 In DATA, write mode, on byte_sync: SHALL assert write=1, data_write=data_in and addr=current address in the next cycle.
REQ-018 In DATA, read mode, on byte_sync: the received byte SHALL be discarded (don't-care).
REQ-019 After each data byte with auto-increment=1: SHALL increment the address by 1 modulo 64 (63 wraps to 0).
  - write: the increment takes effect after that byte's write strobe.
  - read: the next read strobe (pre-fetch for the following byte) is issued 1 cycle after byte_sync, at the incremented address.
REQ-020 With auto-increment=0: further data bytes SHALL reuse the same address.
  - write: each further byte rewrites that register.
  - read: each further byte re-reads that register (fresh read strobe per byte).
REQ-021 SHALL remain in DATA for further bytes (burst) until cs_n is high.
REQ-022 When cs_n=1 is sampled: SHALL return to CMD at the next edge, with no strobe generated for that cycle.
  - A strobe already scheduled from a prior byte_sync SHALL still complete.
REQ-023 byte_sync while cs_n=1 SHALL be ignored.
REQ-024 byte_sync on consecutive cycles SHALL each be processed; strobes appear on consecutive cycles with no drop.
REQ-025 read and write SHALL never be high in the same cycle; each strobe is exactly 1 cycle wide.
REQ-026 addr SHALL hold its last value when no strobe is active.
REQ-027 data_out SHALL hold its value until the next read strobe, including across cs_n high.

Reset
REQ-028 While rst_n=0: SHALL set state=CMD, data_out=0x00, read=0, write=0, addr=0, data_write=0x00, mode/auto-increment flags=0, independent of clk.
REQ-029 Reset asserted mid-frame SHALL abort the transaction with no strobe.
REQ-030 After release, the first byte_sync with cs_n=0 SHALL be decoded as a command.

Verification
REQ-031 Write 0x85 then 0x3C -> single write=1 cycle with addr=5, data_write=0x3C; no read strobe.
REQ-032 Read 0x0A with data_read=0x77 at addr 10:
  - read=1 with addr=10 at byte_sync+1.
  - data_out=0x77 at byte_sync+2.
  - data_out holds 0x77 after cs_n goes high.
REQ-033 Auto-increment write burst 0xFE, 0x11, 0x22, 0x33 -> writes at addr 62, 63, 0 with data 0x11, 0x22, 0x33 (wrap).
REQ-034 Auto-increment read burst 0x7F, two dummy bytes -> read strobes at addr 63, 0, 1; data_out tracks data_read of each.
REQ-035 Abort and reset cases:
  - cs_n high after write command 0x81 (no data byte) -> no write strobe; next byte 0x02 decoded as read command for addr 2.
  - rst_n pulsed mid-burst -> all outputs 0; state CMD.
